// File: rtl/fine_channelizer_pkg.sv
// Shared definitions for the fine channelizer: pipeline latency, full-precision
// widths and the signed component types passed between channelizer blocks.
package fine_channelizer_pkg;

  // Fixed pipeline depth of the complex multiplier before any retiming stages.
  localparam int BASE_LATENCY     = 4;
  localparam int MAX_EXTRA_STAGES = 4;

  // Enabled cycles from in_valid to out_valid for a given number of extra stages.
  function automatic int latency(input int extra_stages);
    return BASE_LATENCY + extra_stages;
  endfunction

  // Width of the stage-3 sum: one bit for the exact -(-2^(B_W-1)) and one for the add.
  function automatic int p_width(input int a_w, input int b_w);
    return a_w + b_w + 2;
  endfunction

  // Default channelizer sample types.
  typedef logic signed [15:0] sample16_t;

  typedef struct packed {
    sample16_t re;
    sample16_t im;
  } cplx16_t;

endpackage

// File: rtl/fine_channelizer_cmul_round.sv
// Stage 4 of the complex multiplier for one component: round half toward +inf,
// arithmetic shift, then wrap or clamp to OUT_W.
// Optional feature macro: FINE_CHANNELIZER_CMUL_SAT_EN (clamp + overflow flag).
module fine_channelizer_cmul_round
  import fine_channelizer_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int SUM_W = IN_W + 1;
  localparam int RW    = (SUM_W > OUT_W) ? SUM_W : OUT_W;
  localparam logic signed [SUM_W-1:0] HALF = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1);

  logic signed [SUM_W-1:0] biased;
  logic signed [RW-1:0]    shifted;

  // Round half toward +inf and bring the result down by SHIFT, sign-extended to RW.
  always_comb begin
    biased  = SUM_W'(din) + HALF;
    shifted = RW'(biased >>> SHIFT);
  end

`ifdef FINE_CHANNELIZER_CMUL_SAT_EN
  localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

  logic signed [OUT_W-1:0] limited;
  logic                    clamp;

  // Clamp to the representable OUT_W range and flag when a clamp happened.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    limited = shifted[OUT_W-1:0];
    clamp   = 1'b0;
    if (shifted > MAX_V) begin
      limited = MAX_V[OUT_W-1:0];
      clamp   = 1'b1;
    end else if (shifted < MIN_V) begin
      limited = MIN_V[OUT_W-1:0];
      clamp   = 1'b1;
    end
  end

  // Stage-4 register for the limited value and its clamp flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      ovf  <= 1'b0;
    end else if (ce) begin
      dout <= limited;
      ovf  <= clamp;
    end
  end
`else
  // Stage-4 register: keep the low OUT_W bits, wrapping modulo 2^OUT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (ce) begin
      dout <= shifted[OUT_W-1:0];
    end
  end

  assign ovf = 1'b0;

  // High bits are intentionally discarded by the wrap.
  if (RW > OUT_W) begin : g_wrap_drop
    logic unused_hi;
    assign unused_hi = ^shifted[RW-1:OUT_W];
  end
`endif

endmodule

// File: rtl/fine_channelizer_cmul.sv
// Pipelined signed complex multiplier: p = a*b or a*conj(b), rounded to OUT_W,
// with valid/user sideband carried alongside and a global clock enable.
// Optional feature macro: FINE_CHANNELIZER_CMUL_SAT_EN (saturate + ovf).
module fine_channelizer_cmul
  import fine_channelizer_pkg::*;
#(
  parameter int A_W          = 16,
  parameter int B_W          = 16,
  parameter int OUT_W        = 16,
  parameter int SHIFT        = 15,
  parameter int USER_W       = 8,
  parameter int EXTRA_STAGES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic signed [A_W-1:0]   a_re,
  input  logic signed [A_W-1:0]   a_im,
  input  logic signed [B_W-1:0]   b_re,
  input  logic signed [B_W-1:0]   b_im,
  input  logic                    conj_b,
  input  logic [USER_W-1:0]       in_user,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] p_re,
  output logic signed [OUT_W-1:0] p_im,
  output logic [USER_W-1:0]       out_user,
  output logic                    ovf
);

  localparam int PP_W = A_W + B_W + 1;
  localparam int P_W  = p_width(A_W, B_W);

  // Stage 1 registers
  logic signed [A_W-1:0] a_re1, a_im1;
  logic signed [B_W-1:0] b_re1;
  logic signed [B_W:0]   b_im1;
  logic signed [B_W:0]   b_im_x;
  logic                  valid1;
  logic [USER_W-1:0]     user1;
  // Stage 2 registers
  logic signed [PP_W-1:0] pp_rr, pp_ii, pp_ri, pp_ir;
  logic                   valid2;
  logic [USER_W-1:0]      user2;
  // Stage 3 registers
  logic signed [P_W-1:0] s_re, s_im;
  logic                  valid3;
  logic [USER_W-1:0]     user3;
  // Stage 4 registers
  logic signed [OUT_W-1:0] re4, im4;
  logic                    ovf_re4, ovf_im4, ovf4;
  logic                    valid4;
  logic [USER_W-1:0]       user4;

  // Widen b_im by one bit so negating -2^(B_W-1) for the conjugate is exact.
  always_comb begin
    b_im_x = (B_W+1)'(b_im);
  end

  // Stages 1-3: capture operands, form partial products, then combine them.
  // NOTE: sequential state uses non-blocking assignments so every stage reads the previous cycle's values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_re1  <= '0;
      a_im1  <= '0;
      b_re1  <= '0;
      b_im1  <= '0;
      valid1 <= 1'b0;
      user1  <= '0;
      pp_rr  <= '0;
      pp_ii  <= '0;
      pp_ri  <= '0;
      pp_ir  <= '0;
      valid2 <= 1'b0;
      user2  <= '0;
      s_re   <= '0;
      s_im   <= '0;
      valid3 <= 1'b0;
      user3  <= '0;
    end else if (ce) begin
      a_re1  <= a_re;
      a_im1  <= a_im;
      b_re1  <= b_re;
      b_im1  <= conj_b ? -b_im_x : b_im_x;
      valid1 <= in_valid;
      user1  <= in_user;
      pp_rr  <= PP_W'(a_re1) * PP_W'(b_re1);
      pp_ii  <= PP_W'(a_im1) * PP_W'(b_im1);
      pp_ri  <= PP_W'(a_re1) * PP_W'(b_im1);
      pp_ir  <= PP_W'(a_im1) * PP_W'(b_re1);
      valid2 <= valid1;
      user2  <= user1;
      s_re   <= P_W'(pp_rr) - P_W'(pp_ii);
      s_im   <= P_W'(pp_ri) + P_W'(pp_ir);
      valid3 <= valid2;
      user3  <= user2;
    end
  end

  fine_channelizer_cmul_round #(.IN_W(P_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_round_re (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .din   (s_re),
    .dout  (re4),
    .ovf   (ovf_re4)
  );

  fine_channelizer_cmul_round #(.IN_W(P_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_round_im (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .din   (s_im),
    .dout  (im4),
    .ovf   (ovf_im4)
  );

  // Stage 4 sideband alongside the rounding instances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid4 <= 1'b0;
      user4  <= '0;
    end else if (ce) begin
      valid4 <= valid3;
      user4  <= user3;
    end
  end

  // Idle slots never report overflow.
  assign ovf4 = (ovf_re4 | ovf_im4) & valid4;

  if (EXTRA_STAGES == 0) begin : g_no_extra
    assign p_re      = re4;
    assign p_im      = im4;
    assign ovf       = ovf4;
    assign out_user  = user4;
    assign out_valid = valid4;
  end else begin : g_extra
    logic signed [OUT_W-1:0] re_q    [EXTRA_STAGES];
    logic signed [OUT_W-1:0] im_q    [EXTRA_STAGES];
    logic                    ovf_q   [EXTRA_STAGES];
    logic [USER_W-1:0]       user_q  [EXTRA_STAGES];
    logic                    valid_q [EXTRA_STAGES];

    // Retiming delay line behind stage 4.
    // NOTE: these register arrays are cleared on reset because reset must zero every pipeline stage.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < EXTRA_STAGES; i++) begin
          re_q[i]    <= '0;
          im_q[i]    <= '0;
          ovf_q[i]   <= 1'b0;
          user_q[i]  <= '0;
          valid_q[i] <= 1'b0;
        end
      end else if (ce) begin
        re_q[0]    <= re4;
        im_q[0]    <= im4;
        ovf_q[0]   <= ovf4;
        user_q[0]  <= user4;
        valid_q[0] <= valid4;
        for (int i = 1; i < EXTRA_STAGES; i++) begin
          re_q[i]    <= re_q[i-1];
          im_q[i]    <= im_q[i-1];
          ovf_q[i]   <= ovf_q[i-1];
          user_q[i]  <= user_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign p_re      = re_q[EXTRA_STAGES-1];
    assign p_im      = im_q[EXTRA_STAGES-1];
    assign ovf       = ovf_q[EXTRA_STAGES-1];
    assign out_user  = user_q[EXTRA_STAGES-1];
    assign out_valid = valid_q[EXTRA_STAGES-1];
  end

endmodule

// File: doc/fine_channelizer_cmul.md
Name: fine_channelizer_cmul

Overview:
- Pipelined, parametrised signed complex multiplier for the fine channelizer.
- Primary use: mixes channel samples with DDS tones (a × b, or a × conj(b)).
- Rounds and optionally saturates the result to a configurable output width.
- Carries a valid/user sideband aligned with the data and stalls cleanly under clock enable.
- Replaces the single 16×16 real multiplier stage used today.

Parameters:
- A_W, 16, width of each component of operand a (signed, two's complement).
- B_W, 16, width of each component of operand b (signed).
- OUT_W, 16, width of each output component (signed).
- SHIFT, 15, right shift applied to the full-precision sum before output; must satisfy 1 ≤ SHIFT < A_W+B_W+1.
- USER_W, 8, width of the sideband passed through with each sample.
- EXTRA_STAGES, 0, additional register stages after rounding (0..4), for timing closure.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when 0, every pipeline register holds.
- in_valid  in  1  input sample qualifier.
- a_re, a_im  in  A_W  operand a.
- b_re, b_im  in  B_W  operand b.
- conj_b  in  1  per-sample: 1 selects a × conj(b).
- in_user  in  USER_W  sideband, delayed with the sample.
- out_valid  out  1  output qualifier.
- p_re, p_im  out  OUT_W  result.
- out_user  out  USER_W  delayed sideband.
- ovf  out  1  per-sample overflow flag; always 0 when FINE_CHANNELIZER_CMUL_SAT_EN is undefined.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all pipeline registers clear to 0. This includes out_valid, p_re, p_im, out_user and ovf.
- Latency is LATENCY = 4 + EXTRA_STAGES enabled cycles, from in_valid=1 to out_valid=1.
- Stage 1: register a, b, conj_b, user and valid. When conj_b=1, negate b_im at this stage into a B_W+1 wide signal, so that −(−2^(B_W−1)) is exact.
- Stage 2: compute the four partial products ar·br, ai·bi, ar·bi, ai·br at full width (A_W+B_W+1) and register them.
- Stage 3: re = ar·br − ai·bi, im = ar·bi + ai·br. Register at width P_W = A_W+B_W+2; no wrap is possible.
- Stage 4 (round and limit):
  - Add 2^(SHIFT−1), then arithmetic-shift right by SHIFT (round half toward +∞).
  - Without saturation: keep the low OUT_W bits (wrap).
  - ovf = 1 for the sample if either component lies outside the OUT_W range (with SAT_EN only).
- EXTRA_STAGES: plain registers appended after stage 4 for data, ovf, user and valid.
- The data path has no reset dependence on valid. Data registers advance whenever ce=1, regardless of valid. Consumers must qualify with out_valid.
- ce=0 freezes all stages, including the valid pipeline. No bubble is inserted and no sample is lost or duplicated. out_valid holds its last value.
- Back-to-back valid samples every cycle are supported at full throughput.
- A reset asserted mid-stream drops all in-flight samples. out_valid is 0 from the cycle reset asserts until LATENCY enabled cycles after the first post-reset in_valid.
- in_valid=0 samples are never flagged with ovf: ovf is ANDed with the stage-4 valid.

Optional Feature:
- Macro: FINE_CHANNELIZER_CMUL_SAT_EN.
- When defined: stage 4 clamps each component to [−2^(OUT_W−1), 2^(OUT_W−1)−1], and ovf reports a clamp on either component.
- When undefined: results wrap modulo 2^OUT_W, ovf is tied to 0, and the comparison logic is omitted.
- Latency is identical in both builds.

Decomposition:
- Package fine_channelizer_pkg holds:
  - LATENCY localparam function of EXTRA_STAGES.
  - P_W width constant expression.
  - Signed component typedef helpers shared with the rest of the channelizer.
- Sub-module fine_channelizer_cmul_round: one instance per component (re, im). It performs the stage-4 round/shift/limit and emits a per-component ovf; the two flags are ORed.

Test Plan:
- Basic product: a=(0x4000,0), b=(0x4000,0), conj_b=0 → after 4 cycles p=(0x2000,0x0000), ovf=0.
- Conjugate: a=(0,0x4000), b=(0,0x4000); conj_b=0 → p=(0xE000,0); conj_b=1 → p=(0x2000,0).
- Rounding:
  - a=(1,0), b=(0x4000,0) → p_re=1.
  - a=(−1,0), b=(0x4000,0) → p_re=0.
- Overflow: a=(−32768,0), b=(−32768,0).
  - Without the macro → p_re=0x8000, ovf=0.
  - With FINE_CHANNELIZER_CMUL_SAT_EN → p_re=0x7FFF, ovf=1.
- Stall and throughput: stream 16 valid samples with incrementing in_user, deasserting ce for 3 cycles mid-stream.
  - Outputs arrive in order, none missing or duplicated.
  - out_user matches each sample's in_user.
  - Latency is 4 enabled cycles; with EXTRA_STAGES=2 it is 6.
- Reset mid-operation: assert reset with 3 samples in flight → out_valid=0 and p=0 immediately. No stale sample emerges after release.
